cmd_arb: RTL
============

// Module: cmd_arb
// PURPOSE
//  Arbitrates the single cmd_cfg command port between the remote link (UART wrapper), an aux requester
//  (autopilot/bench script) and an internal link-loss failsafe. Presents one command at a time as
//  cmd_rdy/cmd/data, holds it until cmd_cfg answers with send_resp, then routes resp to the owner.
//  A watchdog injects an emergency-land command if the remote goes silent while the motors are on.
// PARAMETERS
//  FAST_SIM  1      1: watchdog is 9 bits (timeout 511 clk); 0: watchdog is 26 bits (timeout 2^26-1 clk)
//  FS_CMD    8'h07  opcode issued by the failsafe (EMER_LAND); failsafe data is always 16'h0000
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  rmt_rdy      in   1   remote command valid; level, held until clr_rmt_rdy
//  rmt_cmd      in   8   remote opcode
//  rmt_data     in   16  remote data
//  clr_rmt_rdy  out  1   1-clk pulse: remote command captured
//  rmt_resp_vld out  1   1-clk pulse: rmt_resp valid
//  rmt_resp     out  8   response to remote
//  aux_rdy/aux_cmd/aux_data/clr_aux_rdy/aux_resp_vld/aux_resp: same as rmt_* for aux requester
//  cmd_rdy      out  1   command valid to cmd_cfg
//  cmd          out  8   opcode to cmd_cfg
//  data         out  16  data to cmd_cfg
//  clr_cmd_rdy  in   1   early consume from cmd_cfg (optional, may stay 0)
//  send_resp    in   1   cmd_cfg response strobe
//  resp         in   8   cmd_cfg response byte (0xA5 nominal)
//  motors_off   in   1   from cmd_cfg; 1 = motors stopped
//  lnk_lost     out  1   sticky: failsafe fired, cleared by next granted remote command
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (cmd/data/resps 0, cmd_rdy 0, lnk_lost 0); watchdog 0; rr pointer=remote.
//  - All outputs registered. States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any request pending (fs_req, rmt_rdy, aux_rdy) pick winner; on that edge latch cmd/data/owner,
//    set cmd_rdy, pulse the winner's clr_*_rdy (visible next cycle), go BUSY. No request: stay IDLE.
//  - Priority: fs_req > remote > aux (fixed; see CONFIGURATION for round-robin).
//  - BUSY: cmd/data/owner frozen. cmd_rdy cleared on edge where send_resp or clr_cmd_rdy is 1 (first wins).
//    On send_resp: latch resp, cmd_rdy->0, go RESP. Requests arriving in BUSY wait; no clr pulses.
//  - RESP: one cycle; owner's *_resp_vld=1 with *_resp=latched resp; failsafe owner: resp discarded.
//    Then IDLE; earliest next grant is cycle after RESP (1 bubble), so cmd_cfg always sees cmd_rdy low in its IDLE.
//  - Latency: rmt_rdy high in IDLE cycle N -> cmd_rdy and clr_rmt_rdy high cycle N+1.
//  - Watchdog: cleared while motors_off=1 and on every remote grant; else +1 per clk, saturates at all-ones.
//    At all-ones with fs_done=0: fs_req=1. Failsafe grant sets lnk_lost=1, fs_done=1, fs_req=0.
//    fs_done/lnk_lost cleared by next remote grant (re-arms); fs_done also cleared when motors_off=1.
//  - Simultaneous: watchdog expiry + rmt_rdy in same IDLE cycle -> failsafe granted first, remote next.
//    Expiry while BUSY with aux -> failsafe served at next IDLE ahead of any pending remote/aux.
//  - rdy deasserted by a requester before grant: request withdrawn, no clr pulse.
//  - Async reset mid-transaction: immediate return to reset state; in-flight response dropped, no resp_vld.
// CONFIGURATION
//  CMD_ARB_RR_EN defined: remote/aux arbitration is round-robin; pointer flips to the other requester
//   after each remote or aux grant; failsafe still highest and does not move the pointer.
//  Not defined: fixed remote > aux; aux can starve under continuous remote traffic.
// TESTING
//  1 rmt_rdy cmd=0x02 data=0x0123; send_resp 3 clk after cmd_rdy, resp=0xA5 -> cmd_rdy N+1, clr_rmt_rdy 1 pulse,
//    cmd/data stable until send_resp, rmt_resp_vld 1 pulse with 0xA5, aux_resp_vld stays 0.
//  2 rmt_rdy and aux_rdy asserted same cycle, both re-asserted after each grant -> no RR: remote,remote,remote;
//    with CMD_ARB_RR_EN: remote,aux,remote,aux.
//  3 FAST_SIM=1, motors_off=0, no remote traffic -> cycle 511 fs_req, cmd=0x07 data=0x0000 issued,
//    lnk_lost=1, no *_resp_vld on resp; no second 0x07 until a remote grant; remote grant clears lnk_lost.
//  4 Watchdog expiry coincides with rmt_rdy in IDLE -> 0x07 issued first, then remote command, clr_rmt_rdy only at its grant.
//  5 clr_cmd_rdy pulse 1 clk after cmd_rdy, send_resp 20 clk later -> cmd_rdy drops next clk, state stays BUSY until send_resp.
//  6 rst_n low while BUSY -> all outputs 0 asynchronously; after release no resp_vld for the aborted command.

Source files
------------

// File: rtl/cmd_arb.sv
// cmd_arb: shares the single cmd_cfg command port between the remote link,
// an aux requester and an internal link-loss failsafe. It presents one command
// at a time and holds it until cmd_cfg answers. It then routes the response
// byte back to whichever requester owns the command.
// Optional feature: define CMD_ARB_RR_EN to make remote/aux arbitration
// round-robin. Without it, remote always beats aux.
module cmd_arb #(
   parameter int unsigned FAST_SIM = 1,
   parameter logic [7:0]  FS_CMD   = 8'h07
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rmt_rdy,
   input  logic [7:0]  rmt_cmd,
   input  logic [15:0] rmt_data,
   output logic        clr_rmt_rdy,
   output logic        rmt_resp_vld,
   output logic [7:0]  rmt_resp,
   input  logic        aux_rdy,
   input  logic [7:0]  aux_cmd,
   input  logic [15:0] aux_data,
   output logic        clr_aux_rdy,
   output logic        aux_resp_vld,
   output logic [7:0]  aux_resp,
   output logic        cmd_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   input  logic [7:0]  resp,
   input  logic        motors_off,
   output logic        lnk_lost
);

   localparam int WD_W = (FAST_SIM != 0) ? 9 : 26;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OWN_RMT = 2'd0;
   localparam logic [1:0] OWN_AUX = 2'd1;
   localparam logic [1:0] OWN_FS  = 2'd2;

   logic [1:0]      state_r;
   logic [1:0]      owner_r;
   logic [WD_W-1:0] wd_r;
   logic            fs_done_r;
   logic            fs_req_s;
   logic            gnt_fs_s;
   logic            gnt_rmt_s;
   logic            gnt_aux_s;
   logic            grant_s;
   logic [7:0]      win_cmd_s;
   logic [15:0]     win_data_s;
   logic [1:0]      win_own_s;

`ifdef CMD_ARB_RR_EN
   logic            rr_aux_r;
`endif

   // The failsafe asks for the port once the watchdog saturates, and only until it has been served.
   assign fs_req_s = (&wd_r) & ~fs_done_r;
   assign grant_s  = gnt_fs_s | gnt_rmt_s | gnt_aux_s;

   // Pick a winner, but only in IDLE. The failsafe always goes first.
   always_comb begin
      gnt_fs_s  = 1'b0;
      gnt_rmt_s = 1'b0;
      gnt_aux_s = 1'b0;
      if (state_r != ST_IDLE) begin
         gnt_fs_s = 1'b0;
      end else if (fs_req_s) begin
         gnt_fs_s = 1'b1;
`ifdef CMD_ARB_RR_EN
      end else if (rmt_rdy && aux_rdy) begin
         gnt_aux_s = rr_aux_r;
         gnt_rmt_s = ~rr_aux_r;
`endif
      end else if (rmt_rdy) begin
         gnt_rmt_s = 1'b1;
      end else if (aux_rdy) begin
         gnt_aux_s = 1'b1;
      end else begin
         gnt_rmt_s = 1'b0;
      end
   end

   // Select the command, data and owner of the winning requester.
   always_comb begin
      win_cmd_s  = rmt_cmd;
      win_data_s = rmt_data;
      win_own_s  = OWN_RMT;
      if (gnt_fs_s) begin
         win_cmd_s  = FS_CMD;
         win_data_s = 16'h0000;
         win_own_s  = OWN_FS;
      end else if (gnt_aux_s) begin
         win_cmd_s  = aux_cmd;
         win_data_s = aux_data;
         win_own_s  = OWN_AUX;
      end else begin
         win_cmd_s  = rmt_cmd;
         win_data_s = rmt_data;
         win_own_s  = OWN_RMT;
      end
   end

   // Transaction FSM: grant in IDLE, hold in BUSY, route the response in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_RMT;
         cmd_rdy      <= 1'b0;
         cmd          <= 8'h00;
         data         <= 16'h0000;
         clr_rmt_rdy  <= 1'b0;
         clr_aux_rdy  <= 1'b0;
         rmt_resp_vld <= 1'b0;
         rmt_resp     <= 8'h00;
         aux_resp_vld <= 1'b0;
         aux_resp     <= 8'h00;
      end else begin
         clr_rmt_rdy  <= gnt_rmt_s;
         clr_aux_rdy  <= gnt_aux_s;
         rmt_resp_vld <= 1'b0;
         aux_resp_vld <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  cmd_rdy <= 1'b1;
                  cmd     <= win_cmd_s;
                  data    <= win_data_s;
                  owner_r <= win_own_s;
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (send_resp) begin
                  cmd_rdy <= 1'b0;
                  state_r <= ST_RESP;
                  if (owner_r == OWN_RMT) begin
                     rmt_resp_vld <= 1'b1;
                     rmt_resp     <= resp;
                  end else if (owner_r == OWN_AUX) begin
                     aux_resp_vld <= 1'b1;
                     aux_resp     <= resp;
                  end else begin
                     // The failsafe has nobody to answer, so the byte is dropped.
                     rmt_resp_vld <= 1'b0;
                  end
               end else if (clr_cmd_rdy) begin
                  cmd_rdy <= 1'b0;
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            ST_RESP: begin
               // This is a one-cycle bubble, so cmd_cfg sees cmd_rdy low before the next grant.
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cmd_rdy <= 1'b0;
            end
         endcase
      end
   end

   // Link-loss watchdog and failsafe bookkeeping. A remote grant re-arms everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_r      <= {WD_W{1'b0}};
         fs_done_r <= 1'b0;
         lnk_lost  <= 1'b0;
      end else begin
         if (motors_off || gnt_rmt_s) begin
            wd_r <= {WD_W{1'b0}};
         end else if (!(&wd_r)) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
         end else begin
            wd_r <= wd_r;
         end
         if (gnt_rmt_s) begin
            fs_done_r <= 1'b0;
            lnk_lost  <= 1'b0;
         end else if (gnt_fs_s) begin
            fs_done_r <= 1'b1;
            lnk_lost  <= 1'b1;
         end else if (motors_off) begin
            fs_done_r <= 1'b0;
         end else begin
            fs_done_r <= fs_done_r;
         end
      end
   end

`ifdef CMD_ARB_RR_EN
   // Round-robin pointer: after a remote or aux grant, favour the other requester. The failsafe leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_aux_r <= 1'b0;
      end else if (gnt_rmt_s) begin
         rr_aux_r <= 1'b1;
      end else if (gnt_aux_s) begin
         rr_aux_r <= 1'b0;
      end else begin
         rr_aux_r <= rr_aux_r;
      end
   end
`endif

endmodule
